// File: rtl/axa_fetch_pkg.sv
// Shared AXA definitions used by the fetch stage.
// Contents: word/instruction widths, opcode field slices, the op codes the
// fetch stage must recognise, the NOP word presented when the queue is empty,
// the fetch FSM state type, the queue entry layout and opcode classifiers.
package axa_fetch_pkg;

  localparam int WORD_W = 16;
  localparam int INST_W = 16;

  // Opcode field slices: the 3-bit class field and the 6-bit full opcode.
  localparam int OP_HI  = 15;
  localparam int CLS_LO = 13;
  localparam int OP6_LO = 10;

  localparam logic [2:0] CLS_BRANCH = 3'b101;     // bz / bnz / bn / bnn
  localparam logic [5:0] OP_SYS     = 6'b111000;
  localparam logic [5:0] OP_FAIL    = 6'b110001;
  localparam logic [5:0] OP_NOP     = 6'b111010;

  localparam logic [INST_W-1:0] NOP_WORD = {OP_NOP, 10'b00_0000_0000};

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_BR_WAIT = 2'd1,
    ST_STOP    = 2'd2
  } fetch_state_e;

  // One instruction-queue slot: the word, where it came from, and the last
  // taken-branch address in force when it was fetched.
  typedef struct packed {
    logic [INST_W-1:0] ir;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] lastpc;
  } iq_entry_t;

  function automatic logic is_branch(input logic [INST_W-1:0] w);
    return w[OP_HI] && (w[OP_HI:CLS_LO] == CLS_BRANCH);
  endfunction

  function automatic logic is_stop(input logic [INST_W-1:0] w);
    return w[OP_HI] && ((w[OP_HI:OP6_LO] == OP_SYS) || (w[OP_HI:OP6_LO] == OP_FAIL));
  endfunction

endpackage

// File: rtl/axa_fetch_if.sv
// Fetch-to-decode bundle: the instruction stream handed to decode and the
// branch-resolution signals decode sends back.
//   master (fetch side): drives out_valid/out_ir/out_pc/out_lastpc,
//                        receives out_ready and the branch outcome.
//   slave  (decode side): the mirror image.
interface axa_fetch_if;
  import axa_fetch_pkg::*;

  logic              out_valid;
  logic              out_ready;
  logic [INST_W-1:0] out_ir;
  logic [WORD_W-1:0] out_pc;
  logic [WORD_W-1:0] out_lastpc;
  logic              br_taken;
  logic [WORD_W-1:0] br_target;
  logic              br_nottaken;

  modport master (
    output out_valid, out_ir, out_pc, out_lastpc,
    input  out_ready, br_taken, br_target, br_nottaken
  );

  modport slave (
    input  out_valid, out_ir, out_pc, out_lastpc,
    output out_ready, br_taken, br_target, br_nottaken
  );

endinterface

// File: rtl/axa_fetch_iqueue.sv
// axa_iqueue: parameterised circular FIFO holding fetched instructions.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   flush        - drop every entry (pointers and count back to zero)
//   push, din    - enqueue din; ignored when full or flushing
//   pop          - dequeue head; ignored when empty or flushing
//   dout         - head entry (meaningful only while valid)
//   valid, full  - queue non-empty / queue holds DEPTH entries
module axa_iqueue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify requests against occupancy; a flush cancels both.
  always_comb begin
    push_ok_s = push && (count_r != CNT_FULL) && !flush;
    pop_ok_s  = pop  && (count_r != CNT_ZERO) && !flush;
  end

  // Storage array: written only, never reset (reads are gated by valid).
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= CNT_ZERO;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign valid = (count_r != CNT_ZERO);
  assign full  = (count_r == CNT_FULL);

endmodule

// File: rtl/axa_fetch.sv
// axa_fetch: instruction fetch stage with a small instruction queue.
// Fetches one word per cycle from a combinational instruction memory while
// running and the queue has room. Fetching a branch stalls fetch until decode
// resolves it; fetching sys/fail stops fetch until reset.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   imem_addr   - instruction-memory address (the PC register)
//   imem_data   - word at imem_addr, same cycle
//   dec         - fetch-side bundle: queue head out, branch outcome in
//   stopped     - a stop op has been fetched; fetch idle until reset
module axa_fetch
  import axa_fetch_pkg::*;
#(
  parameter int                QDEPTH   = 2,
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  axa_fetch_if.master       dec,
  output logic              stopped
);

  fetch_state_e      state_r,  state_nx_s;
  logic [WORD_W-1:0] pc_r,     pc_nx_s;
  logic [WORD_W-1:0] lastpc_r, lastpc_nx_s;
  logic [WORD_W-1:0] brpc_r,   brpc_nx_s;   // address of the branch being resolved

  logic      push_s;
  logic      pop_s;
  logic      flush_s;
  logic      q_valid_s;
  logic      q_full_s;
  iq_entry_t q_din_s;
  iq_entry_t q_head_s;

  // State and PC bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_RUN;
      pc_r     <= RESET_PC;
      lastpc_r <= 16'h0000;
      brpc_r   <= 16'h0000;
    end else begin
      state_r  <= state_nx_s;
      pc_r     <= pc_nx_s;
      lastpc_r <= lastpc_nx_s;
      brpc_r   <= brpc_nx_s;
    end
  end

  // Next-state, fetch and redirect decisions.
  always_comb begin
    state_nx_s  = state_r;
    pc_nx_s     = pc_r;
    lastpc_nx_s = lastpc_r;
    brpc_nx_s   = brpc_r;
    push_s      = 1'b0;
    flush_s     = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (!q_full_s) begin
          push_s  = 1'b1;
          pc_nx_s = pc_r + 16'd1;
          if (is_stop(imem_data)) begin
            state_nx_s = ST_STOP;
          end else if (is_branch(imem_data)) begin
            state_nx_s = ST_BR_WAIT;
            brpc_nx_s  = pc_r;
          end else begin
            state_nx_s = ST_RUN;
          end
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_BR_WAIT: begin
        // Decode resolves the branch after taking it from the queue, so
        // anything still queued at a taken redirect is wrong-path.
        if (dec.br_taken) begin
          flush_s     = 1'b1;
          pc_nx_s     = dec.br_target;
          lastpc_nx_s = brpc_r;
          state_nx_s  = ST_RUN;
        end else if (dec.br_nottaken) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_BR_WAIT;
        end
      end
      ST_STOP: begin
        state_nx_s = ST_STOP;
      end
      default: begin
        state_nx_s = ST_RUN;
      end
    endcase
    // A redirect wins over a same-cycle dequeue.
    pop_s = q_valid_s && dec.out_ready && !flush_s;
  end

  // Pack the fetched word with its provenance for the queue.
  always_comb begin
    q_din_s.ir     = imem_data;
    q_din_s.pc     = pc_r;
    q_din_s.lastpc = lastpc_r;
  end

  axa_iqueue #(
    .DEPTH (QDEPTH),
    .WIDTH ($bits(iq_entry_t))
  ) u_iqueue (
    .clk   (clk),
    .reset (reset),
    .flush (flush_s),
    .push  (push_s),
    .din   (q_din_s),
    .pop   (pop_s),
    .dout  (q_head_s),
    .valid (q_valid_s),
    .full  (q_full_s)
  );

  // Present the queue head, or a NOP with zeroed addresses when empty.
  always_comb begin
    dec.out_valid = q_valid_s;
    if (q_valid_s) begin
      dec.out_ir     = q_head_s.ir;
      dec.out_pc     = q_head_s.pc;
      dec.out_lastpc = q_head_s.lastpc;
    end else begin
      dec.out_ir     = NOP_WORD;
      dec.out_pc     = 16'h0000;
      dec.out_lastpc = 16'h0000;
    end
  end

  assign imem_addr = pc_r;
  assign stopped   = (state_r == ST_STOP);

endmodule

// File: tb/tb_axa_fetch.sv
module tb_axa_fetch;

  localparam int          QD     = 2;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic        stopped;
  logic [15:0] mem [0:255];

  int checks   = 0;
  int failures = 0;

  axa_fetch_if bus();

  axa_fetch #(.QDEPTH(QD), .RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .reset     (reset),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .dec       (bus.master),
    .stopped   (stopped)
  );

  always #5 clk = ~clk;

  // Instruction memory: 256 words, aliased across the 16-bit space.
  assign imem_data = mem[imem_addr[7:0]];

  // ---------------- reference model: program-order queue ----------------
  logic [15:0] q_ir[$], q_pc[$], q_lp[$];
  logic [15:0] m_pc, m_lp, m_brpc;
  int          m_mode;   // 0 running, 1 waiting for branch outcome, 2 stopped

  wire [65:0] act = {bus.out_valid, bus.out_ir, bus.out_pc, bus.out_lastpc, imem_addr, stopped};

  function automatic logic [65:0] expv();
    logic st;
    st = (m_mode == 2);
    if (q_pc.size() > 0) return {1'b1, q_ir[0], q_pc[0], q_lp[0], m_pc, st};
    else                 return {1'b0, 16'hE800, 16'h0000, 16'h0000, m_pc, st};
  endfunction

  function automatic bit w_branch(input logic [15:0] w);
    return w[15] && (w[15:13] == 3'b101);
  endfunction

  function automatic bit w_stop(input logic [15:0] w);
    return w[15] && (w[15:10] == 6'b111000 || w[15:10] == 6'b110001);
  endfunction

  task automatic model_update();
    int sz;
    bit deq, fetch;
    logic [15:0] w;
    sz = q_pc.size();
    if (reset) begin
      q_ir.delete(); q_pc.delete(); q_lp.delete();
      m_pc = RST_PC; m_lp = 16'h0000; m_mode = 0;
    end else if (m_mode == 1 && bus.br_taken) begin
      q_ir.delete(); q_pc.delete(); q_lp.delete();
      m_pc = bus.br_target; m_lp = m_brpc; m_mode = 0;
    end else begin
      deq   = (sz > 0) && bus.out_ready;
      fetch = (m_mode == 0) && (sz < QD);
      if (m_mode == 1 && bus.br_nottaken) m_mode = 0;
      if (deq) begin
        void'(q_ir.pop_front()); void'(q_pc.pop_front()); void'(q_lp.pop_front());
      end
      if (fetch) begin
        w = mem[m_pc[7:0]];
        q_ir.push_back(w); q_pc.push_back(m_pc); q_lp.push_back(m_lp);
        if (w_stop(w)) m_mode = 2;
        else if (w_branch(w)) begin m_mode = 1; m_brpc = m_pc; end
        m_pc = m_pc + 16'd1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic fill_plain();
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
  endtask

  task automatic do_reset();
    bus.br_taken = 1'b0; bus.br_nottaken = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    fill_plain();
    bus.out_ready = 1'b0; bus.br_taken = 1'b1; bus.br_nottaken = 1'b1; bus.br_target = 16'h0055;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (act !== expv()) begin failures++; $display("FAIL reset_model got=%h exp=%h", act, expv()); end
    end
    checks++;
    if ({bus.out_valid, bus.out_ir, bus.out_pc, bus.out_lastpc, imem_addr, stopped} !== {1'b0, 16'hE800, 16'h0, 16'h0, RST_PC, 1'b0}) begin
      failures++; $display("FAIL reset_values got=%h exp=%h", act, {1'b0, 16'hE800, 16'h0, 16'h0, RST_PC, 1'b0});
    end
    bus.br_taken = 1'b0; bus.br_nottaken = 1'b0; reset = 1'b0;
  endtask

  task automatic test_in_order();
    fill_plain(); mem[0] = 16'h3012; mem[1] = 16'h8021;
    bus.out_ready = 1'b1;
    do_reset();
    tick();
    checks++;
    if ({bus.out_valid, bus.out_pc, bus.out_ir} !== {1'b1, 16'h0000, 16'h3012}) begin
      failures++; $display("FAIL in_order_0 got=%h exp=%h", {bus.out_valid, bus.out_pc, bus.out_ir}, {1'b1, 16'h0000, 16'h3012});
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.out_pc, bus.out_ir} !== {1'b1, 16'h0001, 16'h8021}) begin
      failures++; $display("FAIL in_order_1 got=%h exp=%h", {bus.out_valid, bus.out_pc, bus.out_ir}, {1'b1, 16'h0001, 16'h8021});
    end
    checks++;
    if (act !== expv()) begin failures++; $display("FAIL in_order_model got=%h exp=%h", act, expv()); end
  endtask

  task automatic test_backpressure();
    logic [15:0] next_pc;
    fill_plain();
    bus.out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (act !== expv()) begin failures++; $display("FAIL bp_stall_model got=%h exp=%h", act, expv()); end
    end
    checks++;
    if ({imem_addr, bus.out_valid, bus.out_pc} !== {16'(QD), 1'b1, 16'h0000}) begin
      failures++; $display("FAIL bp_saturate got=%h exp=%h", {imem_addr, bus.out_valid, bus.out_pc}, {16'(QD), 1'b1, 16'h0000});
    end
    bus.out_ready = 1'b1;
    next_pc = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) begin
        checks++;
        if (bus.out_pc !== next_pc) begin failures++; $display("FAIL bp_order got=%h exp=%h", bus.out_pc, next_pc); end
        next_pc = next_pc + 16'd1;
      end
      tick();
      checks++;
      if (act !== expv()) begin failures++; $display("FAIL bp_drain_model got=%h exp=%h", act, expv()); end
    end
  endtask

  task automatic test_branch_taken();
    bit hit;
    fill_plain(); mem[4] = 16'hA012; mem[8'h20] = 16'h1111; mem[8'h22] = 16'hA000;
    bus.out_ready = 1'b1;
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      tick();
      checks++;
      if (act !== expv()) begin failures++; $display("FAIL bt_model got=%h exp=%h", act, expv()); end
      hit = (m_mode == 1) && (q_pc.size() == 0);
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL bt_wait_timeout got=0 exp=1"); end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({imem_addr, bus.out_valid} !== {16'h0005, 1'b0}) begin
      failures++; $display("FAIL bt_no_fetch got=%h exp=%h", {imem_addr, bus.out_valid}, {16'h0005, 1'b0});
    end
    bus.br_taken = 1'b1; bus.br_target = 16'h0020;
    tick();
    bus.br_taken = 1'b0;
    checks++;
    if ({imem_addr, bus.out_valid} !== {16'h0020, 1'b0}) begin
      failures++; $display("FAIL bt_redirect got=%h exp=%h", {imem_addr, bus.out_valid}, {16'h0020, 1'b0});
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.out_pc, bus.out_lastpc, bus.out_ir} !== {1'b1, 16'h0020, 16'h0004, 16'h1111}) begin
      failures++; $display("FAIL bt_target_head got=%h exp=%h", {bus.out_valid, bus.out_pc, bus.out_lastpc, bus.out_ir}, {1'b1, 16'h0020, 16'h0004, 16'h1111});
    end
  endtask

  // Continues from test_branch_taken: branch at 0x22, lastpc is 4.
  task automatic test_branch_nottaken();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      checks++;
      if (act !== expv()) begin failures++; $display("FAIL bn_model got=%h exp=%h", act, expv()); end
      hit = (m_mode == 1) && (q_pc.size() == 0);
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL bn_wait_timeout got=0 exp=1"); end
    bus.br_nottaken = 1'b1;
    tick();
    bus.br_nottaken = 1'b0;
    checks++;
    if (imem_addr !== 16'h0023) begin failures++; $display("FAIL bn_pc_hold got=%h exp=%h", imem_addr, 16'h0023); end
    tick();
    checks++;
    if ({bus.out_valid, bus.out_pc, bus.out_lastpc} !== {1'b1, 16'h0023, 16'h0004}) begin
      failures++; $display("FAIL bn_resume got=%h exp=%h", {bus.out_valid, bus.out_pc, bus.out_lastpc}, {1'b1, 16'h0023, 16'h0004});
    end
  endtask

  task automatic test_stop();
    logic [15:0] drained[$];
    fill_plain(); mem[2] = 16'hE000;
    bus.out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) drained.push_back(bus.out_pc);
      tick();
      checks++;
      if (act !== expv()) begin failures++; $display("FAIL stop_model got=%h exp=%h", act, expv()); end
    end
    checks++;
    if (drained.size() != 3 || drained[0] !== 16'h0 || drained[1] !== 16'h1 || drained[2] !== 16'h2) begin
      failures++; $display("FAIL stop_drain got=%0d exp=3", drained.size());
    end
    checks++;
    if ({stopped, imem_addr, bus.out_valid, bus.out_ir} !== {1'b1, 16'h0003, 1'b0, 16'hE800}) begin
      failures++; $display("FAIL stop_idle got=%h exp=%h", {stopped, imem_addr, bus.out_valid, bus.out_ir}, {1'b1, 16'h0003, 1'b0, 16'hE800});
    end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++;
    if ({stopped, imem_addr} !== {1'b0, RST_PC}) begin
      failures++; $display("FAIL stop_reset got=%h exp=%h", {stopped, imem_addr}, {1'b0, RST_PC});
    end
  endtask

  task automatic test_reset_in_wait();
    bit hit;
    fill_plain(); mem[1] = 16'hA000;
    bus.out_ready = 1'b1;
    do_reset();
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      hit = (m_mode == 1);
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL rw_wait_timeout got=0 exp=1"); end
    reset = 1'b1; bus.br_taken = 1'b1; bus.br_target = 16'h0040;
    tick();
    reset = 1'b0; bus.br_taken = 1'b0;
    checks++;
    if ({imem_addr, bus.out_valid, stopped} !== {16'h0000, 1'b0, 1'b0}) begin
      failures++; $display("FAIL rw_reset got=%h exp=%h", {imem_addr, bus.out_valid, stopped}, {16'h0000, 1'b0, 1'b0});
    end
    tick();
    checks++;
    if ({bus.out_valid, bus.out_pc, imem_addr} !== {1'b1, 16'h0000, 16'h0001}) begin
      failures++; $display("FAIL rw_run got=%h exp=%h", {bus.out_valid, bus.out_pc, imem_addr}, {1'b1, 16'h0000, 16'h0001});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      reset = ($urandom_range(0, 99) == 0) ||
              (m_mode == 2 && q_pc.size() == 0 && $urandom_range(0, 3) == 0);
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      bus.br_taken    = 1'b0;
      bus.br_nottaken = 1'b0;
      bus.br_target   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      if (m_mode == 1) begin
        if (q_pc.size() == 0 && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 1) == 1) bus.br_taken = 1'b1;
          else                           bus.br_nottaken = 1'b1;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        bus.br_taken    = 1'($urandom_range(0, 1));
        bus.br_nottaken = 1'($urandom_range(0, 1));
      end
      tick();
      checks++;
      if (act !== expv()) begin failures++; $display("FAIL random_model cyc=%0d got=%h exp=%h", c, act, expv()); end
    end
    reset = 1'b0; bus.br_taken = 1'b0; bus.br_nottaken = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.out_ready = 1'b0; bus.br_taken = 1'b0; bus.br_nottaken = 1'b0; bus.br_target = 16'h0000;
    m_pc = RST_PC; m_lp = 16'h0000; m_brpc = 16'h0000; m_mode = 0;
    #2;
    test_reset();
    test_in_order();
    test_backpressure();
    test_branch_taken();
    test_branch_nottaken();
    test_stop();
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axa_fetch.md
AXA_FETCH -- requirements
Module: axa_fetch

Interface
REQ-001 SHALL have parameter QDEPTH, default 2, instruction-queue entries (power of two, 2..8).
REQ-002 SHALL have parameter RESET_PC, default 16'h0000, PC loaded on reset.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port imem_addr, output, 16, instruction-memory read address (equals PC register).
REQ-006 SHALL have port imem_data, input, 16, instruction word at imem_addr, valid same cycle (combinational read).
REQ-007 SHALL have port out_valid, output, 1, queue head holds an instruction.
REQ-008 SHALL have port out_ready, input, 1, decode/register-read stage accepts head this cycle.
REQ-009 SHALL have port out_ir, output, 16, head instruction word; 16'hE800 (NOP: op 111010, rest 0) when out_valid=0.
REQ-010 SHALL have port out_pc, output, 16, address of head instruction.
REQ-011 SHALL have port out_lastpc, output, 16, address of most recent taken branch at the time head was fetched (consumed by land).
REQ-012 SHALL have port br_taken, input, 1, branch resolved taken; redirect.
REQ-013 SHALL have port br_target, input, 16, redirect address, valid with br_taken.
REQ-014 SHALL have port br_nottaken, input, 1, branch resolved not taken; resume sequential fetch.
REQ-015 SHALL have port stopped, output, 1, sys or fail fetched; fetch permanently idle.

Function
REQ-016 SHALL fetch (enqueue {imem_data, pc, lastpc}, pc<=pc+1) in a cycle iff state=RUN and queue count<QDEPTH; otherwise pc holds.
REQ-017 SHALL dequeue head when out_valid and out_ready both 1; simultaneous enqueue and dequeue keeps count unchanged.
REQ-018 SHALL classify a fetched word as branch iff bit15=1 and bits[15:13]=3'b101 (bz/bnz/bn/bnn), and as stop iff bit15=1 and bits[15:10] is 6'b111000 (sys) or 6'b110001 (fail).
REQ-019 SHALL use states RUN, BR_WAIT, STOP; RUN->BR_WAIT on fetching a branch; RUN->STOP on fetching a stop op; BR_WAIT->RUN on br_taken or br_nottaken; STOP exits only on reset.
REQ-020 SHALL on br_taken: pc<=br_target, lastpc register<=pc of the resolving branch (held from its fetch), flush every queue entry younger than the branch, state<=RUN.
REQ-021 SHALL on br_nottaken: state<=RUN, pc unchanged (already branch_pc+1), queue untouched.
REQ-022 SHALL give br_taken priority over out_ready dequeue and enqueue in the same cycle; flush happens, no fetch that cycle.
REQ-023 SHALL ignore br_taken and br_nottaken when state is not BR_WAIT.
REQ-024 SHALL achieve latency: redirect at edge N -> imem_addr=br_target after N, head valid with that word after N+1.
REQ-025 SHALL wrap pc and br_target arithmetic modulo 2^16 (16'hFFFF+1 -> 0).
REQ-026 SHALL in STOP keep enqueued instructions drainable; stopped=1 from the edge the stop op is enqueued.
REQ-027 SHALL keep queue pointers QDEPTH-modulo; no enqueue when full, no dequeue when empty.

Reset
REQ-028 SHALL on reset: pc<=RESET_PC, lastpc<=0, queue empty, state<=RUN; out_valid=0, out_ir=16'hE800, out_pc=0, out_lastpc=0, stopped=0.
REQ-029 SHALL let reset override every other input in the same cycle, including mid-BR_WAIT and STOP.

Structure
REQ-030 SHALL take WORD/INST widths, opcode field slices, the op codes and the NOP word from the shared AXA definitions package.
REQ-031 SHALL implement the queue as one sub-module axa_iqueue (parameterised circular FIFO with flush input).

Verification
REQ-032 SHALL test reset then out_ready=1 with imem words 0x3012,0x8021 at addr 0,1 -> out_pc 0,1 on consecutive cycles, out_ir as stored.
REQ-033 SHALL test out_ready=0 for 5 cycles -> count saturates at QDEPTH, pc=QDEPTH, then resumes in order with no loss.
REQ-034 SHALL test branch 0xA012 at addr 4, br_taken target 0x0020 -> no fetch past addr 4, next out_pc 0x0020, out_lastpc 4.
REQ-035 SHALL test branch at addr 4 with br_nottaken -> next out_pc 5, out_lastpc unchanged.
REQ-036 SHALL test sys 0xE000 at addr 2 -> stopped=1, imem_addr stays 3, instructions 0..2 drained, then out_valid=0, out_ir 0xE800.
REQ-037 SHALL test reset asserted during BR_WAIT -> next cycle pc=0, queue empty, state RUN.
